pipe_stall_ctrl: RTL

Central pipeline stall controller for the 5-stage core. It merges stall requests from the decode and execute stages with its own multi-cycle operation sequencer, and drives the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. Bit order is stall[0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB. Multi-cycle ops are divide and multiply-accumulate; the controller counts their duration and reports completion.

---
 rtl/pipe_stall_ctrl_if.sv | 46 ++++
 rtl/pipe_stall_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall controller.
// Stage side uses the master modport; the controller uses the slave modport.
interface pipe_stall_ctrl_if #(
  parameter int MC_CNT_W = 6,
  parameter int STAT_W   = 32
);
  logic                stallreq_from_id;
  logic                stallreq_from_ex;
  logic                mc_start;
  logic [MC_CNT_W-1:0] mc_cycles;
  logic                flush;
  logic [5:0]          stall;
  logic                mc_busy;
  logic                mc_done;
  logic                stall_timeout;
  logic [STAT_W-1:0]   stat_id_cycles;
  logic [STAT_W-1:0]   stat_ex_cycles;

  modport master (
    output stallreq_from_id,
    output stallreq_from_ex,
    output mc_start,
    output mc_cycles,
    output flush,
    input  stall,
    input  mc_busy,
    input  mc_done,
    input  stall_timeout,
    input  stat_id_cycles,
    input  stat_ex_cycles
  );

  modport slave (
    input  stallreq_from_id,
    input  stallreq_from_ex,
    input  mc_start,
    input  mc_cycles,
    input  flush,
    output stall,
    output mc_busy,
    output mc_done,
    output stall_timeout,
    output stat_id_cycles,
    output stat_ex_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: merges ID/EX requests with a multi-cycle op sequencer
// and a sticky stall watchdog. Define STALL_STATS_EN to build the stall statistics counters.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int TIMEOUT  = 64,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [5:0]          STALL_NONE = 6'b000000;
  localparam logic [5:0]          STALL_ID   = 6'b000111;
  localparam logic [5:0]          STALL_EX   = 6'b001111;
  localparam logic [MC_CNT_W-1:0] CNT_ZERO   = {MC_CNT_W{1'b0}};
  localparam logic [MC_CNT_W-1:0] CNT_ONE    = {{(MC_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]     WD_ZERO    = {WD_W{1'b0}};
  localparam logic [WD_W-1:0]     WD_ONE     = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]     WD_MAX     = WD_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [MC_CNT_W-1:0] cnt_r;
  logic [MC_CNT_W-1:0] cnt_nxt_s;
  logic [MC_CNT_W-1:0] neff_s;
  logic                mc_stall_s;
  logic                mc_done_s;
  logic [5:0]          stall_s;
  logic [WD_W-1:0]     wd_cnt_r;
  logic [WD_W-1:0]     wd_cnt_nxt_s;
  logic                timeout_r;
  logic                timeout_hit_s;

  // Effective op length: a zero-length request still costs one cycle.
  always_comb begin
    if (bus.mc_cycles == CNT_ZERO) begin
      neff_s = CNT_ONE;
    end else begin
      neff_s = bus.mc_cycles;
    end
  end

  // Sequencer next-state, counter update, done pulse and op stall request.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mc_done_s   = 1'b0;
    mc_stall_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (bus.mc_start && !bus.flush) begin
          mc_stall_s = 1'b1;
          if (neff_s == CNT_ONE) begin
            mc_done_s = 1'b1;
          end else begin
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = neff_s - CNT_ONE;
          end
        end else begin
          mc_stall_s = 1'b0;
        end
      end
      ST_BUSY: begin
        mc_stall_s = 1'b1;
        if (bus.flush) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r <= CNT_ONE) begin
          // cnt_r == 0 is unreachable; retire rather than wrap if state is corrupted
          mc_done_s   = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Zero-latency stall vector; EX and multi-cycle ops outrank decode.
  always_comb begin
    if (rst || bus.flush) begin
      stall_s = STALL_NONE;
    end else if (bus.stallreq_from_ex || mc_stall_s) begin
      stall_s = STALL_EX;
    end else if (bus.stallreq_from_id) begin
      stall_s = STALL_ID;
    end else begin
      stall_s = STALL_NONE;
    end
  end

  // Watchdog: consecutive stalled cycles, saturating at TIMEOUT.
  always_comb begin
    if (stall_s == STALL_NONE) begin
      wd_cnt_nxt_s = WD_ZERO;
    end else if (wd_cnt_r >= WD_MAX) begin
      wd_cnt_nxt_s = WD_MAX;
    end else begin
      wd_cnt_nxt_s = wd_cnt_r + WD_ONE;
    end
    timeout_hit_s = (wd_cnt_nxt_s == WD_MAX);
  end

  // Sequencer and watchdog state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      wd_cnt_r  <= WD_ZERO;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      wd_cnt_r  <= wd_cnt_nxt_s;
      timeout_r <= timeout_r | timeout_hit_s;
    end
  end

  assign bus.stall         = stall_s;
  assign bus.mc_busy       = (state_r == ST_BUSY) && !rst;
  assign bus.mc_done       = mc_done_s && !rst && !bus.flush;
  // The flag is visible in the very cycle the count reaches TIMEOUT.
  assign bus.stall_timeout = (timeout_r | timeout_hit_s) && !rst;

`ifdef STALL_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};
  localparam logic [STAT_W-1:0] STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_SAT  = {STAT_W{1'b1}};

  logic [STAT_W-1:0] stat_id_r;
  logic [STAT_W-1:0] stat_ex_r;

  // Saturating per-cause stall cycle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_id_r <= STAT_ZERO;
      stat_ex_r <= STAT_ZERO;
    end else begin
      if ((stall_s == STALL_ID) && (stat_id_r != STAT_SAT)) begin
        stat_id_r <= stat_id_r + STAT_ONE;
      end else begin
        stat_id_r <= stat_id_r;
      end
      if ((stall_s == STALL_EX) && (stat_ex_r != STAT_SAT)) begin
        stat_ex_r <= stat_ex_r + STAT_ONE;
      end else begin
        stat_ex_r <= stat_ex_r;
      end
    end
  end

  assign bus.stat_id_cycles = stat_id_r;
  assign bus.stat_ex_cycles = stat_ex_r;
`else
  assign bus.stat_id_cycles = {STAT_W{1'b0}};
  assign bus.stat_ex_cycles = {STAT_W{1'b0}};
`endif

endmodule
